// File: rtl/core_pkg.sv
// Shared definitions for the 32-bit core pipeline.
// Opcodes, ALU operation codes and instruction field positions.
package core_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SUB  = 6'd1;
   localparam logic [5:0] OP_SHL  = 6'd2;
   localparam logic [5:0] OP_ADDI = 6'd3;
   localparam logic [5:0] OP_SUBI = 6'd4;
   localparam logic [5:0] OP_BEQ  = 6'd5;
   localparam logic [5:0] OP_JUMP = 6'd6;

   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_SHL = 2;

   localparam int OPC_LO = 26;
   localparam int OPC_W  = 6;
   localparam int RS1_LO = 21;
   localparam int RS2_LO = 16;
   localparam int RD_LO  = 11;
   localparam int REG_W  = 5;
   localparam int IMM_LO = 0;
   localparam int IMM_W  = 16;

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: one busy bit per architectural register.
// Ports: set/clear requests, two source queries and one destination query.
module reg_scoreboard
   import core_pkg::*;
#(
   parameter int unsigned SB_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic [4:0] set_idx,
   input  logic       clr_en,
   input  logic [4:0] clr_idx,
   input  logic [4:0] rs1_idx,
   input  logic [4:0] rs2_idx,
   input  logic [4:0] rd_idx,
   output logic       rs1_busy,
   output logic       rs2_busy,
   output logic       rd_busy
);

   logic [31:0] busy_q;
   logic [31:0] busy_d;

   // Set is applied after clear so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_idx] = 1'b0;
      end
      if (set_en) begin
         busy_d[set_idx] = 1'b1;
      end
      busy_d[0] = 1'b0;
      if (SB_EN == 0) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign rs1_busy = busy_q[rs1_idx];
   assign rs2_busy = busy_q[rs2_idx];
   assign rd_busy  = busy_q[rd_idx];

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes one instruction per cycle and holds it
// until the scoreboard clears it; valid/ready on fetch and execute sides.
module decode_stage
   import core_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned ALU_OP_W   = 3,
   parameter int unsigned SB_EN      = 1,
   parameter int unsigned ZEXT_SHIFT = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [XLEN-1:0]     in_pc,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic [XLEN-1:0]     out_imm,
   output logic                out_imm_en,
   output logic                out_is_branch,
   output logic                out_is_jump,
   output logic                out_wr_en,
   output logic                out_illegal,
   input  logic                wb_valid,
   input  logic [4:0]          wb_rd
);

   if (ZEXT_SHIFT != 0) begin : g_bad_zext
      $error("decode_stage: ZEXT_SHIFT must be 0");
   end
   if (XLEN < 16) begin : g_bad_xlen
      $error("decode_stage: XLEN must be >= 16");
   end

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN-1:0]     imm;
      logic                imm_en;
      logic                is_branch;
      logic                is_jump;
      logic                wr_en;
      logic                illegal;
      logic                rs1_en;
      logic                rs2_en;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] ins);
      dec_t            d;
      logic [5:0]      opc;
      logic [4:0]      f_rs1;
      logic [4:0]      f_rs2;
      logic [4:0]      f_rd;
      logic [15:0]     f_imm;
      logic [XLEN-1:0] sext;
      logic [XLEN-1:0] zsh;
      logic            r_type;
      logic            i_type;
      opc    = ins[OPC_LO +: OPC_W];
      f_rs1  = ins[RS1_LO +: REG_W];
      f_rs2  = ins[RS2_LO +: REG_W];
      f_rd   = ins[RD_LO +: REG_W];
      f_imm  = ins[IMM_LO +: IMM_W];
      sext   = XLEN'($signed(f_imm));
      zsh    = XLEN'(f_imm) << 2;
      r_type = opc inside {OP_ADD, OP_SUB, OP_SHL};
      i_type = opc inside {OP_ADDI, OP_SUBI};
      d      = '0;
      unique case (1'b1)
         r_type: begin
            d.alu_op = (opc == OP_SUB) ? ALU_OP_W'(ALU_SUB) :
                       (opc == OP_SHL) ? ALU_OP_W'(ALU_SHL) :
                                         ALU_OP_W'(ALU_ADD);
            d.rs1    = f_rs1;
            d.rs2    = f_rs2;
            d.rd     = f_rd;
            d.wr_en  = (f_rd != 5'd0);
            d.rs1_en = 1'b1;
            d.rs2_en = 1'b1;
         end
         i_type: begin
            d.alu_op = (opc == OP_SUBI) ? ALU_OP_W'(ALU_SUB) :
                                          ALU_OP_W'(ALU_ADD);
            d.rs1    = f_rs1;
            d.rd     = f_rs2;
            d.imm    = sext;
            d.imm_en = 1'b1;
            d.wr_en  = (f_rs2 != 5'd0);
            d.rs1_en = 1'b1;
         end
         (opc == OP_BEQ): begin
            d.alu_op    = ALU_OP_W'(ALU_SUB);
            d.rs1       = f_rs1;
            d.rs2       = f_rs2;
            d.imm       = sext;
            d.is_branch = 1'b1;
            d.rs1_en    = 1'b1;
            d.rs2_en    = 1'b1;
         end
         (opc == OP_JUMP): begin
            d.imm     = zsh;
            d.is_jump = 1'b1;
         end
         default: begin
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

   dec_t            dec_q;
   dec_t            dec_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            held_q;
   logic            held_d;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            rd_busy;
   logic            hazard;
   logic            issue;
   logic            load;

   // Hazard looks only at registered busy state; no writeback bypass.
   assign hazard = held_q &&
                   ((dec_q.rs1_en && rs1_busy) ||
                    (dec_q.rs2_en && rs2_busy) ||
                    (dec_q.wr_en  && rd_busy));

   assign out_valid = held_q && !hazard;
   assign issue     = out_valid && out_ready;
   assign in_ready  = !flush && (!held_q || issue);
   assign load      = in_valid && in_ready;

   always_comb begin
      held_d = held_q;
      dec_d  = dec_q;
      pc_d   = pc_q;
      if (flush) begin
         held_d = 1'b0;
      end else if (load) begin
         held_d = 1'b1;
         dec_d  = decode(in_instr);
         pc_d   = in_pc;
      end else if (issue) begin
         held_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q <= 1'b0;
         dec_q  <= '0;
         pc_q   <= '0;
      end else begin
         held_q <= held_d;
         dec_q  <= dec_d;
         pc_q   <= pc_d;
      end
   end

   // A flushed instruction is wrong-path, so it never claims its rd.
   reg_scoreboard #(
      .SB_EN (SB_EN)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue && !flush && dec_q.wr_en),
      .set_idx  (dec_q.rd),
      .clr_en   (wb_valid),
      .clr_idx  (wb_rd),
      .rs1_idx  (dec_q.rs1),
      .rs2_idx  (dec_q.rs2),
      .rd_idx   (dec_q.rd),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy)
   );

   assign out_pc        = pc_q;
   assign out_alu_op    = dec_q.alu_op;
   assign out_rs1       = dec_q.rs1;
   assign out_rs2       = dec_q.rs2;
   assign out_rd        = dec_q.rd;
   assign out_imm       = dec_q.imm;
   assign out_imm_en    = dec_q.imm_en;
   assign out_is_branch = dec_q.is_branch;
   assign out_is_jump   = dec_q.is_jump;
   assign out_wr_en     = dec_q.wr_en;
   assign out_illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus a random run
// checked against a cycle-level reference model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [2:0]  out_alu_op;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic        out_imm_en;
   logic        out_is_branch;
   logic        out_is_jump;
   logic        out_wr_en;
   logic        out_illegal;
   logic        wb_valid;
   logic [4:0]  wb_rd;

   int checks = 0;
   int errors = 0;

   logic [87:0] outs_all;
   assign outs_all = {out_valid, out_pc, out_alu_op, out_rs1, out_rs2,
                      out_rd, out_imm, out_imm_en, out_is_branch,
                      out_is_jump, out_wr_en, out_illegal};

   always #5 clk = ~clk;

   decode_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_alu_op    (out_alu_op),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_rd        (out_rd),
      .out_imm       (out_imm),
      .out_imm_en    (out_imm_en),
      .out_is_branch (out_is_branch),
      .out_is_jump   (out_is_jump),
      .out_wr_en     (out_wr_en),
      .out_illegal   (out_illegal),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd)
   );

   typedef struct {
      bit [2:0]  op;
      bit [4:0]  rs1;
      bit [4:0]  rs2;
      bit [4:0]  rd;
      bit [31:0] imm;
      bit        imm_en;
      bit        br;
      bit        jmp;
      bit        wr;
      bit        ill;
      bit        r1;
      bit        r2;
   } ref_t;

   // Reference decode written straight from the instruction table.
   function automatic ref_t ref_decode(input bit [31:0] w);
      ref_t r;
      int   opc;
      int   a;
      int   b;
      int   c;
      int   u;
      int   s;
      opc = int'(w / 32'h0400_0000);
      a   = int'((w / 32'h20_0000) % 32);
      b   = int'((w / 32'h1_0000) % 32);
      c   = int'((w / 32'h800) % 32);
      u   = int'(w % 32'h1_0000);
      s   = (u >= 32768) ? u - 65536 : u;
      r   = '{default: 0};
      case (opc)
         0, 1, 2: begin
            r.op = 3'(opc); r.rs1 = 5'(a); r.rs2 = 5'(b); r.rd = 5'(c);
            r.wr = (c != 0); r.r1 = 1; r.r2 = 1;
         end
         3, 4: begin
            r.op = 3'(opc - 3); r.rs1 = 5'(a); r.rd = 5'(b);
            r.imm = 32'(s); r.imm_en = 1; r.wr = (b != 0); r.r1 = 1;
         end
         5: begin
            r.op = 3'd1; r.rs1 = 5'(a); r.rs2 = 5'(b);
            r.imm = 32'(s); r.br = 1; r.r1 = 1; r.r2 = 1;
         end
         6: begin
            r.imm = 32'(u * 4); r.jmp = 1;
         end
         default: r.ill = 1;
      endcase
      return r;
   endfunction

   task automatic idle();
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      wb_valid  = 1'b0;
      wb_rd     = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      #1;
      checks++;
      if (outs_all !== 88'h0) begin
         errors++;
         $display("FAIL reset_outs got %h want 0", outs_all);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release rdy/vld got %b want 10",
                  {in_ready, out_valid});
      end
   endtask

   task automatic test_add();
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h0022_1800; in_pc = 32'h100;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_accept in_ready got %b want 1", in_ready);
      end
      @(negedge clk);
      in_instr = 32'h0C64_FFFF; in_pc = 32'h104;
      #1;
      checks++;
      if ({out_valid, out_alu_op, out_rs1, out_rs2, out_rd, out_wr_en}
          !== {1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1}) begin
         errors++;
         $display("FAIL add_fields got v%b op%0d %0d %0d %0d w%b",
                  out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
                  out_wr_en);
      end
      checks++;
      if (out_pc !== 32'h100) begin
         errors++;
         $display("FAIL add_pc got %h want 100", out_pc);
      end
   endtask

   task automatic test_raw();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_alu_op, out_imm_en, out_imm, out_rs1, out_rd, out_rs2}
          !== {3'd0, 1'b1, 32'hFFFF_FFFF, 5'd3, 5'd4, 5'd0}) begin
         errors++;
         $display("FAIL addi_fields got op%0d ie%b imm%h %0d %0d %0d",
                  out_alu_op, out_imm_en, out_imm, out_rs1, out_rd,
                  out_rs2);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid, in_ready, out_imm} !== {2'b00, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL raw_stall%0d v/r/imm got %b%b %h", i,
                     out_valid, in_ready, out_imm);
         end
         if (i < 2) begin
            @(negedge clk);
            #1;
         end
      end
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = 5'd3;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL raw_no_bypass out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      wb_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL raw_release out_valid got %b want 1", out_valid);
      end
   endtask

   task automatic test_jump();
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h1800_0010; in_pc = 32'h108;
      #1;
      @(negedge clk);
      in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4;
      #1;
      checks++;
      if ({out_valid, out_is_jump, out_wr_en, out_imm, out_pc}
          !== {3'b110, 32'h40, 32'h108}) begin
         errors++;
         $display("FAIL jump got v%b j%b w%b imm%h pc%h", out_valid,
                  out_is_jump, out_wr_en, out_imm, out_pc);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      wb_valid = 1'b0;
      in_valid = 1'b1; in_instr = 32'h0022_1800; in_pc = 32'h200;
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_instr = 32'h1800_0010; in_pc = 32'h204;
         #1;
         checks++;
         if ({out_valid, in_ready, out_pc, out_rs1, out_rs2, out_rd}
             !== {2'b10, 32'h200, 5'd1, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL bp_hold%0d got v%b r%b pc%h %0d %0d %0d", i,
                     out_valid, in_ready, out_pc, out_rs1, out_rs2, out_rd);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release in_ready got %b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_is_jump, out_pc} !== {2'b11, 32'h204}) begin
         errors++;
         $display("FAIL bp_next got v%b j%b pc%h", out_valid, out_is_jump,
                  out_pc);
      end
   endtask

   task automatic test_illegal();
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = 5'd3;
      in_valid = 1'b1; in_instr = 32'hFC00_F800; in_pc = 32'h300;
      #1;
      @(negedge clk);
      wb_valid = 1'b0;
      in_instr = 32'h03E0_1800; in_pc = 32'h304;
      #1;
      checks++;
      if ({out_valid, out_illegal, out_wr_en, out_alu_op, out_is_branch,
           out_is_jump, out_imm_en} !== {2'b11, 1'b0, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL illegal got v%b il%b w%b op%0d b%b j%b ie%b",
                  out_valid, out_illegal, out_wr_en, out_alu_op,
                  out_is_branch, out_is_jump, out_imm_en);
      end
      @(negedge clk);
      in_instr = 32'h0C66_0005; in_pc = 32'h308;
      #1;
      checks++;
      if ({out_valid, out_rs1} !== {1'b1, 5'd31}) begin
         errors++;
         $display("FAIL illegal_no_busy got v%b rs1 %0d want 1 31",
                  out_valid, out_rs1);
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_pre_stall out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1; in_instr = 32'h1800_0010; in_pc = 32'h30C;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_in_ready got %b want 0", in_ready);
      end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL flush_drop v/r got %b%b want 01", out_valid,
                  in_ready);
      end
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h0060_3800; in_pc = 32'h310;
      #1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, out_rs1} !== {2'b00, 5'd3}) begin
         errors++;
         $display("FAIL flush_busy_kept got v%b r%b rs1 %0d", out_valid,
                  in_ready, out_rs1);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs_all !== 88'h0) begin
         errors++;
         $display("FAIL reset_mid_outs got %h want 0", outs_all);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; in_instr = 32'h0C66_0005; in_pc = 32'h400;
      #1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_rs1, out_rd, out_pc}
          !== {1'b1, 5'd3, 5'd6, 32'h400}) begin
         errors++;
         $display("FAIL reset_mid_issue got v%b %0d %0d pc%h", out_valid,
                  out_rs1, out_rd, out_pc);
      end
   endtask

   function automatic bit [31:0] rand_instr();
      int r;
      int opc;
      r   = int'($urandom_range(0, 8));
      opc = (r <= 6) ? r : ((r == 7) ? 7 : 63);
      return (32'(opc) << 26) | (32'($urandom_range(0, 7)) << 21) |
             (32'($urandom_range(0, 7)) << 16) |
             (32'($urandom_range(0, 7)) << 11) |
             32'($urandom_range(0, 2047));
   endfunction

   task automatic test_random();
      bit        m_held;
      bit [31:0] m_instr;
      bit [31:0] m_pc;
      bit        m_busy[32];
      ref_t      rf;
      bit        haz;
      bit        ev;
      bit        er;
      bit        iss;
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      m_held = 0; m_instr = '0; m_pc = '0;
      foreach (m_busy[k]) m_busy[k] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_instr  = rand_instr();
         in_pc     = $urandom;
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         wb_valid  = ($urandom_range(0, 9) < 4);
         wb_rd     = 5'($urandom_range(0, 7));
         #1;
         rf  = ref_decode(m_instr);
         haz = m_held && ((rf.r1 && m_busy[rf.rs1]) ||
                          (rf.r2 && m_busy[rf.rs2]) ||
                          (rf.wr && m_busy[rf.rd]));
         ev  = m_held && !haz;
         er  = !flush && (!m_held || (ev && out_ready));
         checks++;
         if ({out_valid, in_ready} !== {ev, er}) begin
            errors++;
            $display("FAIL rnd_hs cyc%0d v/r got %b%b want %b%b", cyc,
                     out_valid, in_ready, ev, er);
         end
         if (m_held) begin
            checks++;
            if ({out_alu_op, out_rs1, out_rs2, out_rd, out_imm_en,
                 out_is_branch, out_is_jump, out_wr_en, out_illegal}
                !== {rf.op, rf.rs1, rf.rs2, rf.rd, rf.imm_en, rf.br,
                     rf.jmp, rf.wr, rf.ill}) begin
               errors++;
               $display("FAIL rnd_ctrl cyc%0d instr %h got %0d %0d %0d %0d %b%b%b%b%b want %0d %0d %0d %0d %b%b%b%b%b",
                        cyc, m_instr, out_alu_op, out_rs1, out_rs2, out_rd,
                        out_imm_en, out_is_branch, out_is_jump, out_wr_en,
                        out_illegal, rf.op, rf.rs1, rf.rs2, rf.rd,
                        rf.imm_en, rf.br, rf.jmp, rf.wr, rf.ill);
            end
            checks++;
            if ({out_imm, out_pc} !== {rf.imm, m_pc}) begin
               errors++;
               $display("FAIL rnd_imm_pc cyc%0d got %h %h want %h %h", cyc,
                        out_imm, out_pc, rf.imm, m_pc);
            end
         end
         iss = ev && out_ready && !flush;
         if (wb_valid) m_busy[wb_rd] = 0;
         if (iss && rf.wr) m_busy[rf.rd] = 1;
         m_busy[0] = 0;
         if (flush) begin
            m_held = 0;
         end else if (in_valid && er) begin
            m_held = 1; m_instr = in_instr; m_pc = in_pc;
         end else if (iss) begin
            m_held = 0;
         end
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_add();
      test_raw();
      test_jump();
      test_backpressure();
      test_illegal();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode stage for the 32-bit core.
- Decodes one fixed-format instruction per cycle into ALU/branch control, register indices and an extended immediate.
- Holds the decoded instruction in a single output register with valid/ready handshakes on both sides.
- A register scoreboard holds an instruction until its source and destination registers are free. Sits between fetch and execute.

Parameters:
- XLEN, 32: data/immediate width; imm sign- or zero-extended from 16 bits to XLEN (XLEN >= 16).
- ALU_OP_W, 3: width of alu_op.
- SB_EN, 1: 1 = scoreboard active; 0 = busy bits forced 0, no hazard stalls.
- ZEXT_SHIFT, 0: 1 = SHIFTL immediate-free; reserved. Must be 0 in this revision. Elaboration error otherwise.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: fetch presents instruction.
- in_ready, output, 1: stage accepts this cycle.
- in_instr, input, 32: instruction word.
- in_pc, input, XLEN: instruction address.
- flush, input, 1: discard held instruction (branch redirect).
- out_valid, output, 1: decoded instruction issuable.
- out_ready, input, 1: execute accepts.
- out_pc, output, XLEN: pc of held instruction.
- out_alu_op, output, ALU_OP_W: 0 = ADD, 1 = SUB, 2 = SHIFTL.
- out_rs1, output, 5: source index.
- out_rs2, output, 5: source index.
- out_rd, output, 5: destination index.
- out_imm, output, XLEN: extended immediate.
- out_imm_en, output, 1: immediate operand select.
- out_is_branch, output, 1: BEQ.
- out_is_jump, output, 1: JUMP.
- out_wr_en, output, 1: instruction writes out_rd.
- out_illegal, output, 1: undefined opcode.
- wb_valid, input, 1: writeback completes.
- wb_rd, input, 5: register written back.

Behaviour:
- Fields:
  - opcode = instr[31:26], rs1 = [25:21], rs2 = [20:16], rd = [15:11].
  - imm = sign-extended [15:0] for ADDI/SUBI/BEQ.
  - imm = zero-extended [15:0] for JUMP, then shifted left 2 (word target).
- Opcodes:
  - 0 ADD, 1 SUB, 2 SHIFTL: R-type, reads rs1/rs2, writes rd.
  - 3 ADDI, 4 SUBI: I-type, reads rs1, destination = instr[20:16]. out_rd carries it, out_rs2 = 0.
  - 5 BEQ: reads rs1/rs2, no write.
  - 6 JUMP: no reads, no write.
  - Others: out_illegal = 1, out_alu_op = 0, all flags and out_wr_en = 0. Issued normally so execute can trap.
- Writes to r0: out_wr_en = 0.
- Stage state: `held` (1 bit) plus the decoded-field register.
  - in_ready = !held || (out_valid && out_ready); forced 0 while flush = 1.
  - Load on in_valid && in_ready. Latency: decoded fields visible the cycle after acceptance.
- Hazard (combinational, registered state only, no same-cycle wb bypass): held && SB_EN && (busy[rs1] if read || busy[rs2] if read || busy[rd] if out_wr_en).
- out_valid = held && !hazard.
- Issue = out_valid && out_ready.
  - Sets busy[out_rd] if out_wr_en.
  - Clears held unless a new instruction loads the same edge.
- wb_valid clears busy[wb_rd] next edge. If the same index is set and cleared in one cycle, set wins. busy[0] always 0.
- flush:
  - Next edge: held = 0.
  - Busy bits untouched, since unissued instructions never set busy.
  - An instruction presented during flush is not accepted.
- Output fields are stable while held && !out_valid (hold on stall).
- Reset (asynchronous, any time, including mid-stall):
  - held = 0, all busy = 0, in_ready = 1 after release.
  - All out_* = 0.

Decomposition:
- Shared package `core_pkg`:
  - Opcode localparams (OP_ADD..OP_JUMP).
  - ALU op codes (ALU_ADD = 0, ALU_SUB = 1, ALU_SHL = 2).
  - Instruction field bit positions.
- Sub-module `reg_scoreboard` (32 busy bits, set/clear ports, two read-query ports plus one write query, SB_EN gate).
- Pure decode stays in the stage as a combinational function feeding the register.

Test Plan:
- Reset then ADD 0x00221800, pc 0x100, out_ready = 1:
  - Next cycle out_valid = 1, alu_op = 0, rs1 = 1, rs2 = 2, rd = 3, wr_en = 1, out_pc = 0x100.
- ADDI 0x0C64FFFF:
  - alu_op = 0, imm_en = 1, imm = 0xFFFFFFFF, rs1 = 3, rd = 4, rs2 = 0.
  - JUMP 0x18000010 → imm = 0x40, is_jump = 1, wr_en = 0.
- RAW scenario: ADD writing r3 issues, then ADDI reading r3:
  - out_valid = 0, in_ready = 0 until wb_valid, wb_rd = 3.
  - out_valid = 1 exactly one cycle after the wb cycle.
- Backpressure: out_ready = 0 for 3 cycles with held ADD:
  - out fields constant, in_ready = 0.
  - On out_ready = 1, next instruction loads the same edge.
- Opcode 0x3F (0xFC000000):
  - out_illegal = 1, wr_en = 0, no busy bit set.
  - Then flush during a stall → out_valid = 0 next cycle, busy unchanged.
- Assert rst_n low while busy[3] = 1 and held = 1:
  - All outputs 0 immediately, busy cleared.
  - First post-reset ADDI reading r3 issues without stall.
